// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory wrapper port between icache and dcache.
// One outstanding transaction; request fields registered, response steered to owner.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINE_W = 128
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              i_req_valid_i,
  output logic              i_req_ready_o,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic              i_rsp_valid_o,
  input  logic              i_rsp_ready_i,
  input  logic              d_req_valid_i,
  output logic              d_req_ready_o,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic              d_we_i,
  input  logic [DATA_W-1:0] d_data_wr_i,
  output logic              d_rsp_valid_o,
  input  logic              d_rsp_ready_i,
  output logic [ADDR_W-1:0] rsp_addr_o,
  output logic [LINE_W-1:0] rsp_line_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_data_wr_o,
  input  logic              mem_rsp_valid_i,
  output logic              mem_rsp_ready_o,
  input  logic [ADDR_W-1:0] mem_rsp_addr_i,
  input  logic [LINE_W-1:0] mem_data_line_i,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RSP
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] data;
  } req_t;

  localparam logic SRC_I = 1'b0;
  localparam logic SRC_D = 1'b1;

  state_t state, state_n;
  logic   owner, owner_n;
  logic   last_grant, last_n;
  req_t   req_q, req_n;

  logic i_win;
  logic d_win;

  // On a tie the requester that was not served last wins.
  assign d_win = d_req_valid_i &&
                 (!i_req_valid_i || last_grant == SRC_I);
  assign i_win = i_req_valid_i && !d_win;

  always_comb begin
    state_n         = state;
    owner_n         = owner;
    last_n          = last_grant;
    req_n           = req_q;
    i_req_ready_o   = 1'b0;
    d_req_ready_o   = 1'b0;
    i_rsp_valid_o   = 1'b0;
    d_rsp_valid_o   = 1'b0;
    mem_req_valid_o = 1'b0;
    mem_rsp_ready_o = 1'b0;
    unique case (state)
      IDLE: begin
        if (rstn_i) begin
          i_req_ready_o = i_win;
          d_req_ready_o = d_win;
          unique case (1'b1)
            d_win: begin
              req_n   = '{addr: d_addr_i,
                          we:   d_we_i,
                          data: d_data_wr_i};
              owner_n = SRC_D;
              last_n  = SRC_D;
              state_n = REQ;
            end
            i_win: begin
              req_n   = '{addr: i_addr_i,
                          we:   1'b0,
                          data: '0};
              owner_n = SRC_I;
              last_n  = SRC_I;
              state_n = REQ;
            end
            default: ;
          endcase
        end
      end
      REQ: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i)
          state_n = RSP;
      end
      RSP: begin
        if (owner == SRC_D) begin
          d_rsp_valid_o   = mem_rsp_valid_i;
          mem_rsp_ready_o = d_rsp_ready_i;
        end else begin
          i_rsp_valid_o   = mem_rsp_valid_i;
          mem_rsp_ready_o = i_rsp_ready_i;
        end
        if (mem_rsp_valid_i && mem_rsp_ready_o)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= IDLE;
      owner      <= SRC_I;
      last_grant <= SRC_I;
      req_q      <= '0;
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      last_grant <= last_n;
      req_q      <= req_n;
    end
  end

  assign mem_addr_o    = req_q.addr;
  assign mem_we_o      = req_q.we;
  assign mem_data_wr_o = req_q.data;
  assign rsp_addr_o    = mem_rsp_addr_i;
  assign rsp_line_o    = mem_data_line_i;
  assign busy_o        = (state != IDLE);

  // A response outside RSP has no owner; it is left unacknowledged.
  always @(posedge clk_i) begin
    if (rstn_i && state != RSP)
      stray_rsp: assert (!mem_rsp_valid_i)
        else $warning("mem_arbiter: unsolicited memory response ignored");
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run
// against a pending-request round-robin model.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 128;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          i_req_valid_i, i_req_ready_o;
  logic [AW-1:0] i_addr_i;
  logic          i_rsp_valid_o, i_rsp_ready_i;
  logic          d_req_valid_i, d_req_ready_o;
  logic [AW-1:0] d_addr_i;
  logic          d_we_i;
  logic [DW-1:0] d_data_wr_i;
  logic          d_rsp_valid_o, d_rsp_ready_i;
  logic [AW-1:0] rsp_addr_o;
  logic [LW-1:0] rsp_line_o;
  logic          mem_req_valid_o, mem_req_ready_i;
  logic [AW-1:0] mem_addr_o;
  logic          mem_we_o;
  logic [DW-1:0] mem_data_wr_o;
  logic          mem_rsp_valid_i, mem_rsp_ready_o;
  logic [AW-1:0] mem_rsp_addr_i;
  logic [LW-1:0] mem_data_line_i;
  logic          busy_o;

  always #5 clk_i = ~clk_i;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LINE_W(LW)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .i_req_valid_i(i_req_valid_i), .i_req_ready_o(i_req_ready_o),
    .i_addr_i(i_addr_i),
    .i_rsp_valid_o(i_rsp_valid_o), .i_rsp_ready_i(i_rsp_ready_i),
    .d_req_valid_i(d_req_valid_i), .d_req_ready_o(d_req_ready_o),
    .d_addr_i(d_addr_i), .d_we_i(d_we_i), .d_data_wr_i(d_data_wr_i),
    .d_rsp_valid_o(d_rsp_valid_o), .d_rsp_ready_i(d_rsp_ready_i),
    .rsp_addr_o(rsp_addr_o), .rsp_line_o(rsp_line_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_data_wr_o(mem_data_wr_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_ready_o(mem_rsp_ready_o),
    .mem_rsp_addr_i(mem_rsp_addr_i), .mem_data_line_i(mem_data_line_i),
    .busy_o(busy_o)
  );

  int total = 0;
  int bad = 0;
  int mlast = 0;

  typedef struct {
    int            who;
    int            wait_cyc;
    logic          reqv_n;
    logic          reqv_n1;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] data;
    logic [AW-1:0] raddr;
    logic [LW-1:0] line;
    bit            stable;
    bit            rsp_ok;
    int            extra;
  } obs_t;

  // Reference round robin: a lone requester wins, a tie goes to the one not served last.
  function automatic int rr_pick(input bit iv, input bit dv);
    int w;
    if (iv && dv) w = 1 - mlast;
    else w = dv ? 1 : 0;
    mlast = w;
    return w;
  endfunction

  task automatic do_reset();
    rstn_i = 1'b0;
    i_req_valid_i = 0; d_req_valid_i = 0;
    i_rsp_ready_i = 0; d_rsp_ready_i = 0;
    mem_req_ready_i = 0; mem_rsp_valid_i = 0;
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;
    mlast = 0;
  endtask

  // Plays the memory wrapper for one transaction; called at a negedge with requests driven.
  task automatic txn(input int req_stall, input int rsp_stall,
                     input logic [LW-1:0] line, output obs_t o);
    bit own_v, oth_v;
    o.who = -1; o.wait_cyc = 0; o.reqv_n = 0; o.reqv_n1 = 0;
    o.addr = '0; o.we = 0; o.data = '0; o.raddr = '0; o.line = '0;
    o.stable = 1; o.rsp_ok = 1; o.extra = 0;
    #1;
    while (!(i_req_ready_o || d_req_ready_o) && o.wait_cyc < 20) begin
      @(negedge clk_i); #1;
      o.wait_cyc++;
    end
    if (!(i_req_ready_o || d_req_ready_o)) return;
    o.who = d_req_ready_o ? 1 : 0;
    if (i_req_ready_o && d_req_ready_o) o.extra++;
    o.reqv_n = mem_req_valid_o;
    @(negedge clk_i);
    if (o.who == 1) d_req_valid_i = 0; else i_req_valid_i = 0;
    #1;
    o.reqv_n1 = mem_req_valid_o;
    o.addr = mem_addr_o; o.we = mem_we_o; o.data = mem_data_wr_o;
    for (int k = 0; k < req_stall; k++) begin
      if (mem_req_valid_o !== 1'b1 || mem_addr_o !== o.addr ||
          mem_we_o !== o.we || mem_data_wr_o !== o.data ||
          busy_o !== 1'b1 || mem_rsp_ready_o !== 1'b0)
        o.stable = 0;
      if (i_req_ready_o || d_req_ready_o) o.extra++;
      @(negedge clk_i); #1;
    end
    mem_req_ready_i = 1;
    @(negedge clk_i);
    mem_req_ready_i = 0;
    mem_rsp_valid_i = 1;
    mem_rsp_addr_i = o.addr;
    mem_data_line_i = line;
    if (o.who == 1) begin d_rsp_ready_i = 0; i_rsp_ready_i = 1; end
    else begin i_rsp_ready_i = 0; d_rsp_ready_i = 1; end
    #1;
    for (int k = 0; k < rsp_stall; k++) begin
      own_v = (o.who == 1) ? d_rsp_valid_o : i_rsp_valid_o;
      oth_v = (o.who == 1) ? i_rsp_valid_o : d_rsp_valid_o;
      if (own_v !== 1'b1 || oth_v !== 1'b0 || mem_rsp_ready_o !== 1'b0 ||
          busy_o !== 1'b1 || mem_addr_o !== o.addr)
        o.rsp_ok = 0;
      if (i_req_ready_o || d_req_ready_o) o.extra++;
      @(negedge clk_i); #1;
    end
    if (o.who == 1) d_rsp_ready_i = 1; else i_rsp_ready_i = 1;
    #1;
    own_v = (o.who == 1) ? d_rsp_valid_o : i_rsp_valid_o;
    oth_v = (o.who == 1) ? i_rsp_valid_o : d_rsp_valid_o;
    if (own_v !== 1'b1 || oth_v !== 1'b0 || mem_rsp_ready_o !== 1'b1)
      o.rsp_ok = 0;
    o.raddr = rsp_addr_o;
    o.line = rsp_line_o;
    @(negedge clk_i);
    mem_rsp_valid_i = 0;
    i_rsp_ready_i = 0;
    d_rsp_ready_i = 0;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    i_req_valid_i = 1; d_req_valid_i = 1;
    i_addr_i = 32'h10; d_addr_i = 32'h20; d_we_i = 1; d_data_wr_i = 32'h5;
    i_rsp_ready_i = 1; d_rsp_ready_i = 1;
    mem_req_ready_i = 0; mem_rsp_valid_i = 0;
    mem_rsp_addr_i = '0; mem_data_line_i = '0;
    @(negedge clk_i); #1;
    total++;
    if ({i_req_ready_o, d_req_ready_o, i_rsp_valid_o, d_rsp_valid_o,
         mem_req_valid_o, mem_rsp_ready_o, busy_o} !== 7'b0) begin
      bad++;
      $display("FAIL reset_ctl: got %b want 0", {i_req_ready_o, d_req_ready_o,
               i_rsp_valid_o, d_rsp_valid_o, mem_req_valid_o, mem_rsp_ready_o, busy_o});
    end
    total++;
    if ({mem_addr_o, mem_we_o, mem_data_wr_o} !== '0) begin
      bad++;
      $display("FAIL reset_fields: got %h/%b/%h want 0", mem_addr_o, mem_we_o, mem_data_wr_o);
    end
    @(negedge clk_i);
    i_req_valid_i = 0; d_req_valid_i = 0;
    i_rsp_ready_i = 0; d_rsp_ready_i = 0;
    rstn_i = 1'b1;
    mlast = 0;
    @(negedge clk_i);
  endtask

  task automatic test_d_read();
    obs_t o;
    logic [LW-1:0] ln;
    ln = {16{8'hA5}};
    d_req_valid_i = 1; d_addr_i = 32'h100; d_we_i = 0; d_data_wr_i = 32'h0;
    txn(1, 1, ln, o);
    void'(rr_pick(0, 1));
    total++;
    if (o.who !== 1 || o.wait_cyc !== 0) begin
      bad++;
      $display("FAIL dread_grant: got who=%0d wait=%0d want who=1 wait=0", o.who, o.wait_cyc);
    end
    total++;
    if (o.reqv_n !== 1'b0 || o.reqv_n1 !== 1'b1) begin
      bad++;
      $display("FAIL dread_latency: got %b%b want 01", o.reqv_n, o.reqv_n1);
    end
    total++;
    if (o.addr !== 32'h100 || o.we !== 1'b0) begin
      bad++;
      $display("FAIL dread_fields: got %h/%b want 100/0", o.addr, o.we);
    end
    total++;
    if (o.line !== ln || o.raddr !== 32'h100 || !o.rsp_ok) begin
      bad++;
      $display("FAIL dread_rsp: got %h/%h ok=%0d want %h/100 ok=1", o.line, o.raddr, o.rsp_ok, ln);
    end
  endtask

  task automatic test_tie();
    obs_t o;
    do_reset();
    i_req_valid_i = 1; i_addr_i = 32'h200;
    d_req_valid_i = 1; d_addr_i = 32'h300; d_we_i = 0;
    txn(0, 0, {4{32'h1111_2222}}, o);
    total++;
    if (o.who !== rr_pick(1, 1)) begin
      bad++;
      $display("FAIL tie_first: got %0d want 1", o.who);
    end
    txn(0, 0, {4{32'h3333_4444}}, o);
    total++;
    if (o.who !== rr_pick(1, 0) || o.addr !== 32'h200) begin
      bad++;
      $display("FAIL tie_second: got who=%0d addr=%h want 0/200", o.who, o.addr);
    end
    total++;
    if (o.wait_cyc !== 0) begin
      bad++;
      $display("FAIL tie_latency: got wait=%0d want 0", o.wait_cyc);
    end
  endtask

  task automatic test_alternate();
    obs_t o;
    int exp, prev, repeats;
    prev = -1;
    repeats = 0;
    for (int n = 0; n < 6; n++) begin
      i_req_valid_i = 1; d_req_valid_i = 1;
      if (n == 0 || o.who == 0) i_addr_i = 32'h1000 + n;
      if (n == 0 || o.who == 1) d_addr_i = 32'h2000 + n;
      d_we_i = 0;
      txn(0, 0, {4{$urandom}}, o);
      exp = rr_pick(1, 1);
      total++;
      if (o.who !== exp) begin
        bad++;
        $display("FAIL alt_grant%0d: got %0d want %0d", n, o.who, exp);
      end
      if (o.who == prev) repeats++;
      prev = o.who;
    end
    total++;
    if (repeats !== 0) begin
      bad++;
      $display("FAIL alt_fair: got repeats=%0d want 0", repeats);
    end
    i_req_valid_i = 0; d_req_valid_i = 0;
  endtask

  task automatic test_write();
    obs_t o;
    d_req_valid_i = 1; d_addr_i = 32'h4000_0000; d_we_i = 1; d_data_wr_i = 32'h1;
    txn(0, 3, {4{32'hCAFE_F00D}}, o);
    void'(rr_pick(0, 1));
    total++;
    if (o.who !== 1 || o.we !== 1'b1 || o.data !== 32'h1 || o.addr !== 32'h4000_0000) begin
      bad++;
      $display("FAIL write_fields: got who=%0d %h/%b/%h want 1 40000000/1/1",
               o.who, o.addr, o.we, o.data);
    end
    total++;
    if (!o.rsp_ok) begin
      bad++;
      $display("FAIL write_hold: got rsp_ok=%0d want 1", o.rsp_ok);
    end
    #1;
    total++;
    if (busy_o !== 1'b0) begin
      bad++;
      $display("FAIL write_idle: got busy=%b want 0", busy_o);
    end
  endtask

  task automatic test_stall();
    obs_t o;
    int exp;
    i_req_valid_i = 1; i_addr_i = 32'h0000_0ABC;
    d_req_valid_i = 1; d_addr_i = 32'h0000_0DEF; d_we_i = 1; d_data_wr_i = 32'h77;
    txn(5, 3, {4{32'h0F0F_0F0F}}, o);
    exp = rr_pick(1, 1);
    total++;
    if (o.who !== exp || o.addr !== (exp == 1 ? 32'h0DEF : 32'h0ABC)) begin
      bad++;
      $display("FAIL stall_grant: got %0d/%h want %0d", o.who, o.addr, exp);
    end
    total++;
    if (!o.stable || !o.rsp_ok) begin
      bad++;
      $display("FAIL stall_stable: got %0d%0d want 11", o.stable, o.rsp_ok);
    end
    total++;
    if (o.extra !== 0) begin
      bad++;
      $display("FAIL stall_onegrant: got extra=%0d want 0", o.extra);
    end
    txn(0, 0, {4{32'h1}}, o);
    exp = rr_pick(exp == 1, exp == 0);
    total++;
    if (o.who !== exp) begin
      bad++;
      $display("FAIL stall_next: got %0d want %0d", o.who, exp);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    d_req_valid_i = 1; d_addr_i = 32'h0000_0500; d_we_i = 1; d_data_wr_i = 32'h9;
    @(negedge clk_i);
    d_req_valid_i = 0;
    mem_req_ready_i = 1;
    @(negedge clk_i);
    mem_req_ready_i = 0;
    mem_rsp_valid_i = 1; mem_rsp_addr_i = 32'h500;
    i_req_valid_i = 1; i_addr_i = 32'h0000_0600;
    d_req_valid_i = 1; d_rsp_ready_i = 0; i_rsp_ready_i = 1;
    #1;
    total++;
    if (busy_o !== 1'b1 || d_rsp_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL rmid_pre: got busy=%b dv=%b want 1/1", busy_o, d_rsp_valid_o);
    end
    rstn_i = 1'b0;
    #1;
    total++;
    if ({i_req_ready_o, d_req_ready_o, i_rsp_valid_o, d_rsp_valid_o,
         mem_req_valid_o, mem_rsp_ready_o, busy_o, mem_we_o} !== 8'b0 ||
        mem_addr_o !== '0 || mem_data_wr_o !== '0) begin
      bad++;
      $display("FAIL rmid_async: got %b %h %h want 0", {i_req_ready_o, d_req_ready_o,
               i_rsp_valid_o, d_rsp_valid_o, mem_req_valid_o, mem_rsp_ready_o,
               busy_o, mem_we_o}, mem_addr_o, mem_data_wr_o);
    end
    @(negedge clk_i);
    mem_rsp_valid_i = 0; d_req_valid_i = 0; i_rsp_ready_i = 0;
    rstn_i = 1'b1;
    mlast = 0;
    txn(0, 0, {4{32'hBEEF_0001}}, o);
    total++;
    if (o.who !== rr_pick(1, 0) || o.addr !== 32'h600 || o.we !== 1'b0 ||
        o.data !== '0 || o.wait_cyc !== 0) begin
      bad++;
      $display("FAIL rmid_after: got who=%0d %h/%b/%h wait=%0d want 0 600/0/0 0",
               o.who, o.addr, o.we, o.data, o.wait_cyc);
    end
  endtask

  task automatic test_unsolicited();
    mem_rsp_valid_i = 1; mem_rsp_addr_i = 32'h123;
    i_rsp_ready_i = 1; d_rsp_ready_i = 1;
    #1;
    total++;
    if (mem_rsp_ready_o !== 1'b0 || i_rsp_valid_o !== 1'b0 || d_rsp_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL unsol_idle: got %b%b%b want 000", mem_rsp_ready_o, i_rsp_valid_o, d_rsp_valid_o);
    end
    mem_rsp_valid_i = 0; i_rsp_ready_i = 0; d_rsp_ready_i = 0;
    @(negedge clk_i); #1;
    total++;
    if (busy_o !== 1'b0) begin
      bad++;
      $display("FAIL unsol_state: got busy=%b want 0", busy_o);
    end
    @(negedge clk_i);
  endtask

  task automatic test_random();
    obs_t o;
    bit pi, pd, dwe;
    logic [AW-1:0] ia, da, ea;
    logic [DW-1:0] dd;
    logic [LW-1:0] ln;
    int exp;
    pi = 0; pd = 0; ia = '0; da = '0; dd = '0; dwe = 0;
    for (int n = 0; n < 24; n++) begin
      if (!pi && $urandom_range(0, 1) == 1) begin
        pi = 1; ia = $urandom;
      end
      if (!pd && ($urandom_range(0, 1) == 1 || !pi)) begin
        pd = 1; da = $urandom; dwe = 1'($urandom_range(0, 1)); dd = $urandom;
      end
      i_req_valid_i = pi; i_addr_i = ia;
      d_req_valid_i = pd; d_addr_i = da; d_we_i = dwe; d_data_wr_i = dd;
      ln = {$urandom, $urandom, $urandom, $urandom};
      exp = rr_pick(pi, pd);
      ea = (exp == 1) ? da : ia;
      txn($urandom_range(0, 2), $urandom_range(0, 2), ln, o);
      total++;
      if (o.who !== exp || o.extra !== 0) begin
        bad++;
        $display("FAIL rnd_grant%0d: got %0d extra=%0d want %0d", n, o.who, o.extra, exp);
      end
      total++;
      if (o.addr !== ea || o.we !== (exp == 1 ? dwe : 1'b0) ||
          o.data !== (exp == 1 ? dd : 32'h0) || !o.stable ||
          o.reqv_n !== 1'b0 || o.reqv_n1 !== 1'b1) begin
        bad++;
        $display("FAIL rnd_fields%0d: got %h/%b/%h st=%0d want %h", n,
                 o.addr, o.we, o.data, o.stable, ea);
      end
      total++;
      if (o.line !== ln || o.raddr !== ea || !o.rsp_ok) begin
        bad++;
        $display("FAIL rnd_rsp%0d: got %h ok=%0d want %h", n, o.line, o.rsp_ok, ln);
      end
      if (exp == 1) pd = 0; else pi = 0;
    end
    i_req_valid_i = 0; d_req_valid_i = 0;
  endtask

  initial begin
    test_reset();
    test_d_read();
    test_tie();
    test_alternate();
    test_write();
    test_stall();
    test_reset_mid();
    test_unsolicited();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
